// File: rtl/instruction_fetcher.sv
// -----------------------------------------------------------------------------
// instruction_fetcher
//
// Front end of the decode/dispatch path. Owns the PC, keeps at most one word
// fetch outstanding on the instruction-memory port, and buffers returned words
// in a small FIFO. Each buffered word is offered downstream with its own PC and
// a statically predicted next PC:
//   jal    -> redirected locally to pc + J-immediate
//   jalr   -> fetch stalls until the resolved target arrives
//   others -> pc + 4 (branches predicted not-taken)
// A flush from the ROB empties the queue and restarts fetch at flush_pc. A
// response that is still in flight when the flush lands is dropped.
//
// Ports
//   clk_in, rst_in             clock, asynchronous active-high reset
//   rdy_in                     global enable; when low nothing changes
//   mem_req_valid/addr/ready   fetch request channel (addr = PC)
//   mem_resp_valid/data        single-cycle response pulse carrying the word
//   inst_valid/out/pc/pred_pc  queue head offered to the consumer
//   inst_ready                 consumer takes the head
//   flush_in, flush_pc         squash everything and restart at flush_pc
//   jalr_done_in, jalr_target  resolved target releasing a jalr stall
// -----------------------------------------------------------------------------
module instruction_fetcher #(
    parameter int          IQ_WIDTH = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pred_pc,
    input  logic        inst_ready,
    input  logic        flush_in,
    input  logic [31:0] flush_pc,
    input  logic        jalr_done_in,
    input  logic [31:0] jalr_target
);

    localparam int DEPTH = 1 << IQ_WIDTH;
    localparam logic [IQ_WIDTH-1:0] PTR_ONE = IQ_WIDTH'(1);
    localparam logic [IQ_WIDTH:0]   CNT_ONE = (IQ_WIDTH + 1)'(1);

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_pc;
    logic [31:0]         w_pc_nxt;
    // Keeps the request channel quiet until the first edge after reset release.
    logic                r_live;

    logic [IQ_WIDTH-1:0] r_head;
    logic [IQ_WIDTH-1:0] r_tail;
    logic [IQ_WIDTH:0]   r_count;
    logic [31:0]         r_q_inst [DEPTH];
    logic [31:0]         r_q_pc   [DEPTH];
    logic [31:0]         r_q_pred [DEPTH];

    logic                w_full;
    logic                w_inst_valid;
    logic                w_req_valid;
    logic                w_req_fire;
    logic                w_flush;
    logic                w_push;
    logic                w_pop;
    logic [6:0]          w_opcode;
    logic                w_is_jal;
    logic                w_is_jalr;
    logic [31:0]         w_jimm;
    logic [31:0]         w_pc_plus4;
    logic [31:0]         w_pred;

    // count never exceeds DEPTH, so its MSB alone marks a full queue.
    assign w_full       = r_count[IQ_WIDTH];
    assign w_inst_valid = (r_count != '0);

    assign w_req_valid = r_live && (r_state == S_FETCH) && !w_full && !flush_in;
    assign w_req_fire  = w_req_valid && mem_req_ready && rdy_in;
    assign w_flush     = flush_in && rdy_in;
    assign w_push      = rdy_in && !flush_in && (r_state == S_WAIT) && mem_resp_valid;
    assign w_pop       = rdy_in && !flush_in && w_inst_valid && inst_ready;

    assign w_opcode   = mem_resp_data[6:0];
    assign w_is_jal   = (w_opcode == OPC_JAL);
    assign w_is_jalr  = (w_opcode == OPC_JALR);
    assign w_jimm     = {{11{mem_resp_data[31]}}, mem_resp_data[31], mem_resp_data[19:12],
                         mem_resp_data[20], mem_resp_data[30:21], 1'b0};
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pred     = w_is_jal ? (r_pc + w_jimm) : w_pc_plus4;

    // Next state / next PC. Flush outranks every other event in the cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (w_flush) begin
            w_pc_nxt = flush_pc;
            case (r_state)
                // A response arriving in the flush cycle closes the outstanding
                // request, so there is nothing left to drain.
                S_WAIT, S_DRAIN: w_state_nxt = mem_resp_valid ? S_FETCH : S_DRAIN;
                // The request is masked while flush_in is high, so FETCH never
                // has an acceptance to drain here; STALL is simply cancelled.
                default:         w_state_nxt = S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_req_fire) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        if (w_is_jalr) begin
                            w_state_nxt = S_STALL;
                        end else begin
                            w_pc_nxt    = w_pred;
                            w_state_nxt = S_FETCH;
                        end
                    end
                end
                S_STALL: begin
                    if (jalr_done_in) begin
                        w_pc_nxt    = jalr_target;
                        w_state_nxt = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (mem_resp_valid) begin
                        w_state_nxt = S_FETCH;
                    end
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_live  <= 1'b0;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_live  <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage carries no reset; the head is masked while the queue is empty.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_q_inst[r_tail] <= mem_resp_data;
            r_q_pc[r_tail]   <= r_pc;
            r_q_pred[r_tail] <= w_pred;
        end
    end

    assign mem_req_valid = w_req_valid;
    assign mem_req_addr  = w_req_valid ? r_pc : 32'h0;
    assign inst_valid    = w_inst_valid;
    assign inst_out      = w_inst_valid ? r_q_inst[r_head] : 32'h0;
    assign inst_pc       = w_inst_valid ? r_q_pc[r_head]   : 32'h0;
    assign inst_pred_pc  = w_inst_valid ? r_q_pred[r_head] : 32'h0;

endmodule

// File: tb/tb_instruction_fetcher.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetcher
//
// Directed bench for instruction_fetcher: straight-line fetch, jal redirect,
// queue-full back-pressure, flush in WAIT and in FETCH, jalr stall/resume,
// rdy_in hold and an asynchronous reset pulse mid-request.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instruction_fetcher;

    localparam logic [31:0] ADDI = 32'h0000_0013;
    localparam logic [31:0] JAL  = 32'h0200_006F;
    localparam logic [31:0] JALR = 32'h0000_8067;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] inst_pred_pc;
    logic        inst_ready;
    logic        flush_in;
    logic [31:0] flush_pc;
    logic        jalr_done_in;
    logic [31:0] jalr_target;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetcher #(
        .IQ_WIDTH(2),
        .RESET_PC(32'h0)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .inst_valid    (inst_valid),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .inst_pred_pc  (inst_pred_pc),
        .inst_ready    (inst_ready),
        .flush_in      (flush_in),
        .flush_pc      (flush_pc),
        .jalr_done_in  (jalr_done_in),
        .jalr_target   (jalr_target)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Wait (bounded) for a request, check its address, then accept it.
    task automatic do_accept(input string tag, input logic [31:0] exp_addr);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req_valid"}, {31'd0, mem_req_valid}, 32'd1);
        chk({tag, "_req_addr"}, mem_req_addr, exp_addr);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        do_accept(tag, addr);
        respond(data);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] pred,
                            input logic [31:0] inst);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        chk({tag, "_pc"}, inst_pc, pc);
        chk({tag, "_pred"}, inst_pred_pc, pred);
        chk({tag, "_inst"}, inst_out, inst);
    endtask

    task automatic pop();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        int bad;
        rst_in         = 1'b1;
        rdy_in         = 1'b1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        inst_ready     = 1'b0;
        flush_in       = 1'b0;
        flush_pc       = 32'h0;
        jalr_done_in   = 1'b0;
        jalr_target    = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'h0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_pred", inst_pred_pc, 32'h0);
        rst_in = 1'b0;

        // Sequential fetch of three addi words
        do_fetch("f0", 32'h0, ADDI);
        do_fetch("f4", 32'h4, ADDI);
        do_fetch("f8", 32'h8, ADDI);
        chk_head("h0", 32'h0, 32'h4, ADDI);
        pop();
        chk_head("h4", 32'h4, 32'h8, ADDI);
        pop();
        chk_head("h8", 32'h8, 32'hC, ADDI);
        pop();
        chk("empty_after_pops", {31'd0, inst_valid}, 32'd0);

        // jal redirect: 0x10 + 0x20 = 0x30
        do_fetch("fC", 32'hC, ADDI);
        do_fetch("f10", 32'h10, JAL);
        chk_head("hC", 32'hC, 32'h10, ADDI);
        pop();
        chk_head("h10_jal", 32'h10, 32'h30, JAL);
        pop();

        // Queue full back-pressure
        do_fetch("f30", 32'h30, ADDI);
        do_fetch("f34", 32'h34, ADDI);
        do_fetch("f38", 32'h38, ADDI);
        do_fetch("f3C", 32'h3C, ADDI);
        bad = 0;
        repeat (3) begin
            if (mem_req_valid) bad++;
            tick();
        end
        chk("full_no_request", bad, 0);
        chk_head("h30", 32'h30, 32'h34, ADDI);
        pop();
        chk("after_pop_req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("after_pop_req_addr", mem_req_addr, 32'h40);
        chk_head("h34", 32'h34, 32'h38, ADDI);
        pop();
        chk_head("h38", 32'h38, 32'h3C, ADDI);

        // Flush while a request is outstanding
        do_accept("f40", 32'h40);
        flush_in = 1'b1;
        flush_pc = 32'h100;
        tick();
        flush_in = 1'b0;
        chk("flushW_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("flushW_req_valid", {31'd0, mem_req_valid}, 32'd0);
        bad = 0;
        repeat (2) begin
            if (mem_req_valid || inst_valid) bad++;
            tick();
        end
        chk("drain_quiet", bad, 0);
        respond(JAL);
        chk("drain_discard", {31'd0, inst_valid}, 32'd0);
        chk("drain_req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("drain_req_addr", mem_req_addr, 32'h100);

        // Flush while idle in FETCH, then jalr stall
        do_fetch("f100", 32'h100, ADDI);
        chk_head("h100", 32'h100, 32'h104, ADDI);
        flush_in = 1'b1;
        flush_pc = 32'h20;
        #1;
        chk("flushF_req_masked", {31'd0, mem_req_valid}, 32'd0);
        tick();
        flush_in = 1'b0;
        chk("flushF_inst_valid", {31'd0, inst_valid}, 32'd0);
        do_fetch("f20", 32'h20, JALR);
        chk_head("h20_jalr", 32'h20, 32'h24, JALR);
        bad = 0;
        repeat (10) begin
            if (mem_req_valid) bad++;
            tick();
        end
        chk("stall_no_request", bad, 0);
        jalr_done_in = 1'b1;
        jalr_target  = 32'h44;
        tick();
        jalr_done_in = 1'b0;
        chk("jalr_req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("jalr_req_addr", mem_req_addr, 32'h44);

        // rdy_in low during WAIT holds everything, including the queue head
        do_accept("f44", 32'h44);
        rdy_in     = 1'b0;
        inst_ready = 1'b1;
        bad = 0;
        repeat (5) begin
            if (!inst_valid || inst_pc != 32'h20 || mem_req_valid) bad++;
            tick();
        end
        chk("rdy_hold", bad, 0);
        rdy_in     = 1'b1;
        inst_ready = 1'b0;
        respond(ADDI);
        chk_head("h20_kept", 32'h20, 32'h24, JALR);
        pop();
        chk_head("h44", 32'h44, 32'h48, ADDI);

        // Asynchronous reset pulse mid-WAIT
        do_accept("f48", 32'h48);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("arst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        rst_in = 1'b0;
        do_fetch("f0_again", 32'h0, ADDI);
        chk_head("h0_again", 32'h0, 32'h4, ADDI);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
